// File: rtl/pipe_hazard_ctrl_if.sv
//------------------------------------------------------------------------------
// pipe_hazard_ctrl_if : hazard-status inputs and stall/flush controls of the
//                       pipeline hazard controller.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pipe_hazard_ctrl_if #(
  parameter int IDX_W = 5,
  parameter int CNT_W = 16
);
  logic [IDX_W-1:0] d_rs1_index;
  logic [IDX_W-1:0] d_rs2_index;
  logic             d_rs1_used;
  logic             d_rs2_used;
  logic [IDX_W-1:0] e_rd_index;
  logic             e_wb_en;
  logic             e_is_load;
  logic             e_mispredict;
  logic             e_ecall;
  logic             mem_busy;
  logic             resume;
  logic             pc_stall;
  logic             fd_stall;
  logic             fd_flush;
  logic             de_stall;
  logic             de_flush;
  logic             halted;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output d_rs1_index, d_rs2_index, d_rs1_used, d_rs2_used,
    output e_rd_index, e_wb_en, e_is_load, e_mispredict, e_ecall,
    output mem_busy, resume,
    input  pc_stall, fd_stall, fd_flush, de_stall, de_flush, halted, bubble_cnt
  );

  modport slave (
    input  d_rs1_index, d_rs2_index, d_rs1_used, d_rs2_used,
    input  e_rd_index, e_wb_en, e_is_load, e_mispredict, e_ecall,
    input  mem_busy, resume,
    output pc_stall, fd_stall, fd_flush, de_stall, de_flush, halted, bubble_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
//------------------------------------------------------------------------------
// pipe_hazard_ctrl : stall/flush controller for the 5-stage RV32 pipeline
//                    (load-use, mispredict, mem wait, ecall halt).  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int IDX_W        = 5,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [3:0]       DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  logic [IDX_W-1:0] rs1_idx, rs2_idx, rd_idx;
  logic             load_use;
  logic             pc_stall, fd_stall, fd_flush, de_stall, de_flush;

  assign rs1_idx = bus.d_rs1_index;
  assign rs2_idx = bus.d_rs2_index;
  assign rd_idx  = bus.e_rd_index;

  assign load_use = bus.e_is_load && bus.e_wb_en && (rd_idx != '0) &&
                    ((bus.d_rs1_used && (rs1_idx == rd_idx)) ||
                     (bus.d_rs2_used && (rs2_idx == rd_idx)));

  always_comb begin
    pc_stall = 1'b0;
    fd_stall = 1'b0;
    fd_flush = 1'b0;
    de_stall = 1'b0;
    de_flush = 1'b0;
    state_d  = state_q;
    drain_d  = drain_q;
    halted_d = halted_q;

    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          if (bus.mem_busy) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_stall = 1'b1;
          end else if (bus.e_mispredict) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
          end else if (bus.e_ecall) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            state_d  = ST_DRAIN;
            drain_d  = DRAIN_INIT;
          end else if (load_use) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_flush = 1'b1;
          end
        end
        ST_DRAIN: begin
          // A memory wait freezes the drain countdown so M/W really retire.
          if (bus.mem_busy) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_stall = 1'b1;
          end else begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_flush = 1'b1;
            if (drain_q == 4'd0) begin
              state_d  = ST_HALT;
              halted_d = 1'b1;
            end else begin
              drain_d = drain_q - 4'd1;
            end
          end
        end
        ST_HALT: begin
          pc_stall = 1'b1;
          fd_stall = 1'b1;
          de_flush = 1'b1;
          if (bus.resume) begin
            state_d  = ST_RUN;
            halted_d = 1'b0;
          end
        end
        default: begin
          state_d  = ST_RUN;
          drain_d  = 4'd0;
          halted_d = 1'b0;
        end
      endcase
    end

    bubble_d = (de_flush && (bubble_q != CNT_MAX)) ? bubble_q + CNT_W'(1) : bubble_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      drain_q  <= 4'd0;
      halted_q <= 1'b0;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= halted_d;
      bubble_q <= bubble_d;
    end
  end

  assign bus.pc_stall   = pc_stall;
  assign bus.fd_stall   = fd_stall;
  assign bus.fd_flush   = fd_flush;
  assign bus.de_stall   = de_stall;
  assign bus.de_flush   = de_flush;
  assign bus.halted     = halted_q;
  assign bus.bubble_cnt = bubble_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
//------------------------------------------------------------------------------
// tb_pipe_hazard_ctrl : directed bench for pipe_hazard_ctrl with a cycle-level
//                       reference model.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int TB_IDX_W = 5;
  localparam int TB_DRAIN = 2;
  localparam int TB_CNT_W = 4;
  localparam int BUB_MAX  = (1 << TB_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.IDX_W(TB_IDX_W), .CNT_W(TB_CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .IDX_W       (TB_IDX_W),
    .DRAIN_CYCLES(TB_DRAIN),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: mode 0=running, 1=draining, 2=halted.
  int m_mode = 0;
  int m_left = 0;
  int m_halt = 0;
  int m_bub  = 0;
  bit m_ok   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_load_use();
    if (!(bus.e_is_load && bus.e_wb_en) || bus.e_rd_index == 0) return 1'b0;
    if (bus.d_rs1_used && bus.d_rs1_index == bus.e_rd_index) return 1'b1;
    if (bus.d_rs2_used && bus.d_rs2_index == bus.e_rd_index) return 1'b1;
    return 1'b0;
  endfunction

  // Expected {pc_stall, fd_stall, fd_flush, de_stall, de_flush}.
  function automatic logic [4:0] model_comb();
    if (rst)                return 5'b00000;
    if (m_mode == 2)        return 5'b11001;
    if (bus.mem_busy)       return 5'b11010;
    if (m_mode == 1)        return 5'b11001;
    if (bus.e_mispredict)   return 5'b00101;
    if (bus.e_ecall)        return 5'b11101;
    if (model_load_use())   return 5'b11001;
    return 5'b00000;
  endfunction

  always @(posedge clk) begin
    logic [4:0] e;
    if (rst) begin
      m_mode = 0; m_left = 0; m_halt = 0; m_bub = 0; m_ok = 1'b1;
    end else if (m_ok) begin
      e = model_comb();
      if (e[0]) m_bub = (m_bub < BUB_MAX) ? m_bub + 1 : BUB_MAX;
      if (m_mode == 2) begin
        if (bus.resume) begin m_mode = 0; m_halt = 0; end
      end else if (!bus.mem_busy) begin
        if (m_mode == 1) begin
          if (m_left == 0) begin m_mode = 2; m_halt = 1; end
          else m_left = m_left - 1;
        end else if (!bus.e_mispredict && bus.e_ecall) begin
          m_mode = 1; m_left = TB_DRAIN - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] e;
    if (m_ok) begin
      e = model_comb();
      chk("cmp_pc_stall", int'(bus.pc_stall), int'(e[4]));
      chk("cmp_fd_stall", int'(bus.fd_stall), int'(e[3]));
      chk("cmp_fd_flush", int'(bus.fd_flush), int'(e[2]));
      chk("cmp_de_stall", int'(bus.de_stall), int'(e[1]));
      chk("cmp_de_flush", int'(bus.de_flush), int'(e[0]));
      chk("cmp_halted",   int'(bus.halted),   m_halt);
      chk("cmp_bubble",   int'(bus.bubble_cnt), m_bub);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.d_rs1_index  = '0;
    bus.d_rs2_index  = '0;
    bus.d_rs1_used   = 1'b0;
    bus.d_rs2_used   = 1'b0;
    bus.e_rd_index   = '0;
    bus.e_wb_en      = 1'b0;
    bus.e_is_load    = 1'b0;
    bus.e_mispredict = 1'b0;
    bus.e_ecall      = 1'b0;
    bus.mem_busy     = 1'b0;
    bus.resume       = 1'b0;
  endtask

  task automatic set_load(input int rd);
    bus.e_is_load  = 1'b1;
    bus.e_wb_en    = 1'b1;
    bus.e_rd_index = TB_IDX_W'(rd);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cyc(); cyc();
    rst = 1'b0;
    mid();
    chk("reset_halted", int'(bus.halted), 0);
    chk("reset_bubble", int'(bus.bubble_cnt), 0);
    chk("reset_pc_stall", int'(bus.pc_stall), 0);
    cyc();

    // Load-use on rs1: exactly one bubble.
    set_load(5); bus.d_rs1_index = 5'd5; bus.d_rs1_used = 1'b1;
    mid();
    chk("lu_pc_stall", int'(bus.pc_stall), 1);
    chk("lu_fd_stall", int'(bus.fd_stall), 1);
    chk("lu_de_flush", int'(bus.de_flush), 1);
    chk("lu_fd_flush", int'(bus.fd_flush), 0);
    cyc();
    idle();
    mid();
    chk("lu_after_pc", int'(bus.pc_stall), 0);
    chk("lu_bubble", int'(bus.bubble_cnt), 1);
    cyc();

    // No false hazards: x0 destination, unused rs2.
    set_load(0); bus.d_rs1_index = 5'd0; bus.d_rs1_used = 1'b1;
    mid();
    chk("x0_pc_stall", int'(bus.pc_stall), 0);
    cyc();
    set_load(5); bus.d_rs1_index = 5'd3; bus.d_rs1_used = 1'b1;
    bus.d_rs2_index = 5'd5; bus.d_rs2_used = 1'b0;
    mid();
    chk("rs2unused_pc", int'(bus.pc_stall), 0);
    chk("rs2unused_df", int'(bus.de_flush), 0);
    cyc();
    bus.d_rs2_used = 1'b1;
    mid();
    chk("rs2_lu_pc", int'(bus.pc_stall), 1);
    cyc();
    idle();

    // Mispredict beats a simultaneous load-use.
    set_load(7); bus.d_rs1_index = 5'd7; bus.d_rs1_used = 1'b1; bus.e_mispredict = 1'b1;
    mid();
    chk("mp_fd_flush", int'(bus.fd_flush), 1);
    chk("mp_de_flush", int'(bus.de_flush), 1);
    chk("mp_pc_stall", int'(bus.pc_stall), 0);
    chk("mp_fd_stall", int'(bus.fd_stall), 0);
    cyc();
    idle();
    mid();
    chk("mp_bubble", int'(bus.bubble_cnt), 3);

    // mem_busy overrides mispredict and ecall in RUN.
    bus.mem_busy = 1'b1; bus.e_mispredict = 1'b1; bus.e_ecall = 1'b1;
    mid();
    chk("busy_de_stall", int'(bus.de_stall), 1);
    chk("busy_fd_flush", int'(bus.fd_flush), 0);
    cyc();
    idle();

    // ecall: flush, two drain cycles, halt, resume.
    bus.e_ecall = 1'b1;
    mid();
    chk("ec_fd_flush", int'(bus.fd_flush), 1);
    chk("ec_pc_stall", int'(bus.pc_stall), 1);
    cyc();
    idle();
    mid();
    chk("dr1_halted", int'(bus.halted), 0);
    chk("dr1_fd_flush", int'(bus.fd_flush), 0);
    chk("dr1_de_flush", int'(bus.de_flush), 1);
    cyc();
    mid();
    chk("dr2_halted", int'(bus.halted), 0);
    cyc();
    bus.e_mispredict = 1'b1; bus.e_ecall = 1'b1;
    mid();
    chk("halt_halted", int'(bus.halted), 1);
    chk("halt_pc_stall", int'(bus.pc_stall), 1);
    chk("halt_fd_flush", int'(bus.fd_flush), 0);
    cyc();
    idle();
    bus.resume = 1'b1;
    mid();
    chk("resume_cycle_halted", int'(bus.halted), 1);
    chk("resume_cycle_pc", int'(bus.pc_stall), 1);
    cyc();
    bus.resume = 1'b0;
    mid();
    chk("resumed_halted", int'(bus.halted), 0);
    chk("resumed_pc", int'(bus.pc_stall), 0);
    chk("resumed_bubble", int'(bus.bubble_cnt), 8);
    cyc();

    // mem_busy during DRAIN with drain_cnt=1 freezes the countdown.
    bus.e_ecall = 1'b1;
    cyc();
    idle();
    bus.mem_busy = 1'b1;
    repeat (3) begin
      mid();
      chk("dbusy_de_stall", int'(bus.de_stall), 1);
      chk("dbusy_de_flush", int'(bus.de_flush), 0);
      cyc();
    end
    bus.mem_busy = 1'b0;
    mid();
    chk("dbusy_bubble", int'(bus.bubble_cnt), 9);
    cyc();
    mid();
    chk("dbusy_edge1_halted", int'(bus.halted), 0);
    cyc();
    mid();
    chk("dbusy_edge2_halted", int'(bus.halted), 1);
    bus.mem_busy = 1'b1;
    mid();
    chk("hbusy_de_stall", int'(bus.de_stall), 0);
    chk("hbusy_de_flush", int'(bus.de_flush), 1);
    cyc();
    bus.mem_busy = 1'b0;

    // Saturation in HALT, then reset out of HALT.
    repeat (20) cyc();
    mid();
    chk("sat_bubble", int'(bus.bubble_cnt), 15);
    rst = 1'b1;
    mid();
    chk("rst_pc_stall", int'(bus.pc_stall), 0);
    chk("rst_de_flush", int'(bus.de_flush), 0);
    cyc();
    rst = 1'b0;
    mid();
    chk("post_rst_halted", int'(bus.halted), 0);
    chk("post_rst_bubble", int'(bus.bubble_cnt), 0);
    chk("post_rst_pc", int'(bus.pc_stall), 0);
    cyc();
    cyc();
    mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RV32 pipeline.
- Drives the fetch/decode and decode/execute pipeline registers.
- Detects load-use hazards, branch/jump mispredicts resolved in E, and data-memory wait. Sequences ecall (drain, halt, resume).
- Keeps a saturating bubble counter for performance monitoring.

Parameters:
- IDX_W, 5, register index width
- DRAIN_CYCLES, 2, post-ecall cycles to let M/W retire before halt; legal range 1..15
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- d_rs1_index  in  IDX_W  rs1 of instruction in D
- d_rs2_index  in  IDX_W  rs2 of instruction in D
- d_rs1_used  in  1  D instruction reads rs1
- d_rs2_used  in  1  D instruction reads rs2
- e_rd_index  in  IDX_W  rd of instruction in E
- e_wb_en  in  1  E instruction writes back
- e_is_load  in  1  E instruction is a load (wb_sel from memory)
- e_mispredict  in  1  E branch/jump outcome differs from guess
- e_ecall  in  1  ecall in E
- mem_busy  in  1  data memory not ready this cycle
- resume  in  1  leave HALT
- pc_stall  out  1  hold PC
- fd_stall  out  1  hold F/D register
- fd_flush  out  1  bubble F/D register
- de_stall  out  1  hold D/E register
- de_flush  out  1  load NOP controls into D/E register
- halted  out  1  registered, core halted
- bubble_cnt  out  CNT_W  registered count of cycles with de_flush=1

Behaviour:
- States: RUN, DRAIN, HALT. drain_cnt is 4 bits.
- Reset, sampled on the clk edge with rst=1:
  - state=RUN, drain_cnt=0, halted=0, bubble_cnt=0.
  - While rst=1, all combinational stall/flush outputs are 0.
- Stall/flush outputs are combinational from state and the current inputs, so they act in the same cycle. halted and bubble_cnt are registered.
- load_use is true when all of these hold:
  - e_is_load=1, e_wb_en=1 and e_rd_index!=0;
  - (d_rs1_used and d_rs1_index==e_rd_index) or (d_rs2_used and d_rs2_index==e_rd_index).
- mem_busy=1 in RUN or DRAIN:
  - pc_stall=fd_stall=de_stall=1, fd_flush=de_flush=0.
  - State and drain_cnt hold.
  - mispredict, ecall and load_use are ignored; the frozen E re-presents them later.
  - Overrides all other RUN/DRAIN rules.
- RUN with mem_busy=0, in priority order:
  - e_mispredict: fd_flush=de_flush=1, pc_stall=fd_stall=de_stall=0, so the PC redirect proceeds. Any simultaneous ecall or load_use is dropped.
  - e_ecall: pc_stall=fd_stall=1, fd_flush=de_flush=1. Next state DRAIN with drain_cnt=DRAIN_CYCLES-1.
  - load_use: pc_stall=fd_stall=1, de_flush=1, fd_flush=0. Exactly one bubble results, because the next cycle E holds a NOP and load_use clears.
  - Otherwise: all outputs 0.
- DRAIN with mem_busy=0:
  - pc_stall=fd_stall=1, de_flush=1.
  - If drain_cnt==0, next state is HALT and halted=1 on that edge. Otherwise drain_cnt decrements.
- HALT:
  - pc_stall=fd_stall=1, de_flush=1, halted=1. mem_busy, mispredict and ecall are ignored.
  - resume=1 sampled: next state RUN and halted=0. Outputs in the resume cycle are still HALT values.
  - resume in RUN or DRAIN is ignored.
- bubble_cnt: increments by 1 each non-reset cycle with de_flush=1. It saturates at all-ones and does not wrap.
- Reset mid-DRAIN or mid-HALT returns to RUN next cycle with counters cleared.
- Total latency from ecall in E to halted=1 is DRAIN_CYCLES+1 edges, excluding mem_busy cycles.

Test Plan:
1. Load-use: e_is_load=1, e_wb_en=1, e_rd_index=5, d_rs1_index=5, d_rs1_used=1 -> one cycle of pc_stall=fd_stall=de_flush=1. Next cycle (E=NOP) all 0. bubble_cnt=1.
2. No false hazard:
   - e_rd_index=0 with d_rs1_index=0 -> no stall;
   - d_rs2_index=5 with d_rs2_used=0 -> no stall.
3. Mispredict plus load_use same cycle -> fd_flush=de_flush=1, pc_stall=0, fd_stall=0, bubble_cnt +1 only.
4. Ecall, DRAIN_CYCLES=2:
   - cycle 0: flush+stall;
   - cycles 1-2: DRAIN;
   - halted=1 after the 3rd edge, stalls persist;
   - resume=1 for 1 cycle -> RUN and halted=0 on the following edge.
5. mem_busy=1 for 3 cycles during DRAIN with drain_cnt=1 -> stalls all 1, flushes 0, drain_cnt holds at 1. HALT reached 2 edges after mem_busy drops.
6. Saturation/reset:
   - CNT_W=4 and 20 HALT cycles -> bubble_cnt=15.
   - rst=1 in HALT -> next cycle state=RUN, halted=0, bubble_cnt=0, all outputs 0.
